servo_pwm_multi: RTL and testbench
==================================

Name: servo_pwm_multi

Overview:
Parametrised multi-channel RC-servo PWM generator for the line-follower steering and auxiliary servos. It replaces per-servo single-channel timing with one shared microsecond prescaler and frame counter. Each channel has a latched target position and a per-frame slew-rate limiter, so the mechanics never see step commands. It sits between the steering controller, which supplies targets, and the output pins.

Parameters:
CLK_HZ, 100_000_000, input clock frequency; must be an integer multiple of 1_000_000
CHANNELS, 2, number of independent servo outputs (1..8)
POS_W, 8, position word width per channel
FRAME_US, 20000, PWM frame period in microseconds
MIN_US, 1000, pulse width for position 0
MAX_US, 2000, nominal pulse width at full scale
SLEW_STEP, 4, maximum change of current position per frame, in position units; 0 means no slew limit

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
target_pos  in  CHANNELS*POS_W  packed target positions; channel i occupies bits [i*POS_W +: POS_W]
load  in  1  single-cycle strobe; latches all of target_pos into the target registers
enable  in  1  1 = drive pulses; 0 = all pwm low and slew frozen
pwm  out  CHANNELS  servo pulse outputs
cur_pos  out  CHANNELS*POS_W  current (slewed) position per channel
frame_tick  out  1  one-clk pulse on every frame boundary
busy  out  1  high while any cur_pos differs from its target

Behaviour:
- Reset, asynchronous, in the cycle rst rises:
  - pwm=0, frame_tick=0, busy=0
  - prescaler=0, us_cnt=0
  - every target and cur_pos = 2^(POS_W-1) (centre)
  - width registers = width(centre)
- Prescaler: counts 0..CLK_HZ/1e6-1. us_tick asserts on its last count.
- us_cnt: 0..FRAME_US-1, advances on us_tick.
- Frame boundary (FB): the cycle where us_tick=1 and us_cnt=FRAME_US-1. In that cycle:
  - us_cnt←0
  - frame_tick←1 for exactly one clk
  - cur_pos and width are updated
- Slew at FB, per channel, only if enable=1:
  - d = target - cur
  - if |d| <= SLEW_STEP (or SLEW_STEP=0): cur←target
  - else: cur←cur ± SLEW_STEP
  - No wrap-around; arithmetic is done in POS_W+1 bits signed.
- Width function: width = MIN_US + ((cur * (MAX_US-MIN_US)) >> POS_W).
  - Computed from the post-update cur and registered at FB.
  - Widths only change at FB, so a pulse is never truncated or stretched mid-frame.
- pwm[i] is registered: pwm[i] ← enable && (us_cnt_next < width[i]).
  - Output rises one clk after FB.
  - High time is exactly width[i] µs.
- load: target registers ← target_pos on the next edge.
  - If load coincides with FB, the slew step uses the old target; the new target takes effect from the next FB.
- enable=0: pwm forced low on the next edge. Counters keep running; cur_pos frozen.
  - On re-enable, pulses resume from the current frame position, only if us_cnt < width.
- busy: registered OR over channels of (cur != target).
- Reset mid-pulse: pwm drops immediately (asynchronous); the frame restarts from 0 after release.
- Width arithmetic uses POS_W + clog2(MAX_US-MIN_US+1) bits; no overflow.

Test Plan:
Bench parameters: CLK_HZ=1_000_000 (1 clk = 1 µs), CHANNELS=2, POS_W=8, FRAME_US=20000, MIN_US=1000, MAX_US=2000, SLEW_STEP=4.
- Reset release, enable=1 -> cur_pos=128/128 on both channels; each pwm high 1500 clks out of every 20000; frame_tick period 20000 clks.
- load with ch0=255 -> busy=1; cur_pos0 rises 132, 136, … per frame and reaches 255 after 32 FBs; then busy=0 and pwm0 high time = 1996 clks; ch1 stays at 1500.
- load with ch1=0 -> cur_pos1 reaches 0 after 32 FBs; final high time 1000 clks; no wrap past 0.
- load asserted exactly in the FB cycle with ch0=130 (from 128) -> that FB leaves cur unchanged; the next FB sets cur=130, width 1507.
- enable=0 for 3 frames during slew -> pwm stays 0 and cur_pos stays constant; after enable=1, slewing resumes from the frozen value.
- Assert rst 700 clks into a 1500-clk pulse -> pwm=0 in the same cycle; after release, state is all-centre and the first pulse starts at the first FB.

Source files
------------

// File: rtl/servo_pwm_multi_if.sv
// Command/status bundle between the steering controller and servo_pwm_multi.
interface servo_pwm_multi_if #(
    parameter int CHANNELS = 2,
    parameter int POS_W    = 8
);
    logic [CHANNELS*POS_W-1:0] target_pos;
    logic                      load;
    logic                      enable;
    logic [CHANNELS-1:0]       pwm;
    logic [CHANNELS*POS_W-1:0] cur_pos;
    logic                      frame_tick;
    logic                      busy;

    modport master (output target_pos, load, enable,
                    input  pwm, cur_pos, frame_tick, busy);
    modport slave  (input  target_pos, load, enable,
                    output pwm, cur_pos, frame_tick, busy);
endinterface

// File: rtl/servo_pwm_multi.sv
// Multi-channel RC-servo PWM: shared microsecond prescaler and frame counter,
// per-channel latched target with a per-frame slew limiter.
module servo_pwm_lane #(
    parameter int POS_W     = 8,
    parameter int CNT_W     = 15,
    parameter int WID_W     = 11,
    parameter int MIN_US    = 1000,
    parameter int MAX_US    = 2000,
    parameter int SLEW_STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fb,
    input  logic             enable,
    input  logic             load,
    input  logic             armed,
    input  logic [CNT_W-1:0] us_cnt_nxt,
    input  logic [POS_W-1:0] tgt_in,
    output logic             pwm,
    output logic [POS_W-1:0] cur,
    output logic             neq
);
    localparam int SPAN   = MAX_US - MIN_US;
    localparam int PROD_W = POS_W + $clog2(SPAN + 1);
    localparam int SW     = POS_W + 1;
    localparam int CMP_W  = (CNT_W > WID_W) ? CNT_W : WID_W;
    localparam logic [POS_W-1:0]        CENTRE    = {1'b1, {(POS_W-1){1'b0}}};
    localparam logic [WID_W-1:0]        WIDTH_RST = WID_W'(MIN_US + SPAN / 2);
    localparam logic signed [SW-1:0]    STEP_S    = SW'(SLEW_STEP);

    logic [POS_W-1:0]     tgt_q, tgt_d, cur_q, cur_d;
    logic [WID_W-1:0]     width_q, width_d;
    logic                 pwm_q, pwm_d;
    logic signed [SW-1:0] diff;

    function automatic logic [WID_W-1:0] width_of(input logic [POS_W-1:0] p);
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(p) * PROD_W'(SPAN);
        return WID_W'(MIN_US) + WID_W'(prod >> POS_W);
    endfunction

    always_comb begin
        tgt_d = load ? tgt_in : tgt_q;
        cur_d = cur_q;
        diff  = $signed({1'b0, tgt_q}) - $signed({1'b0, cur_q});
        // Slew uses the target held before this edge, so a load in the FB cycle waits a frame.
        if (fb && enable) begin
            if (SLEW_STEP == 0 || (diff <= STEP_S && diff >= -STEP_S))
                cur_d = tgt_q;
            else if (!diff[SW-1])
                cur_d = cur_q + POS_W'(SLEW_STEP);
            else
                cur_d = cur_q - POS_W'(SLEW_STEP);
        end
        width_d = fb ? width_of(cur_d) : width_q;
        pwm_d   = armed && enable && (CMP_W'(us_cnt_nxt) < CMP_W'(width_d));
        neq     = (cur_d != tgt_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt_q   <= CENTRE;
            cur_q   <= CENTRE;
            width_q <= WIDTH_RST;
            pwm_q   <= 1'b0;
        end else begin
            tgt_q   <= tgt_d;
            cur_q   <= cur_d;
            width_q <= width_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm = pwm_q;
    assign cur = cur_q;
endmodule

module servo_pwm_multi #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int CHANNELS  = 2,
    parameter int POS_W     = 8,
    parameter int FRAME_US  = 20000,
    parameter int MIN_US    = 1000,
    parameter int MAX_US    = 2000,
    parameter int SLEW_STEP = 4
) (
    input logic              clk,
    input logic              rst,
    servo_pwm_multi_if.slave bus
);
    localparam int DIV   = CLK_HZ / 1_000_000;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W = $clog2(FRAME_US);
    localparam int WID_W = $clog2(MAX_US + 1);

    logic [PRE_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] us_cnt_q, us_cnt_d;
    logic             us_tick, fb;
    logic             frame_tick_q, frame_tick_d;
    logic             armed_q, armed_d;
    logic             busy_q, busy_d;
    logic [CHANNELS-1:0]            neq;
    logic [CHANNELS-1:0]            pwm_w;
    logic [CHANNELS-1:0][POS_W-1:0] cur_w;

    always_comb begin
        us_tick  = (presc_q == PRE_W'(DIV - 1));
        presc_d  = us_tick ? '0 : presc_q + PRE_W'(1);
        fb       = us_tick && (us_cnt_q == CNT_W'(FRAME_US - 1));
        us_cnt_d = us_cnt_q;
        if (fb)
            us_cnt_d = '0;
        else if (us_tick)
            us_cnt_d = us_cnt_q + CNT_W'(1);
        frame_tick_d = fb;
        // Pulses are held off after reset until the first full frame begins.
        armed_d      = armed_q | fb;
        busy_d       = |neq;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            us_cnt_q     <= '0;
            frame_tick_q <= 1'b0;
            armed_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            us_cnt_q     <= us_cnt_d;
            frame_tick_q <= frame_tick_d;
            armed_q      <= armed_d;
            busy_q       <= busy_d;
        end
    end

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_lane
            servo_pwm_lane #(
                .POS_W(POS_W), .CNT_W(CNT_W), .WID_W(WID_W),
                .MIN_US(MIN_US), .MAX_US(MAX_US), .SLEW_STEP(SLEW_STEP)
            ) u_lane (
                .clk       (clk),
                .rst       (rst),
                .fb        (fb),
                .enable    (bus.enable),
                .load      (bus.load),
                .armed     (armed_d),
                .us_cnt_nxt(us_cnt_d),
                .tgt_in    (bus.target_pos[i*POS_W +: POS_W]),
                .pwm       (pwm_w[i]),
                .cur       (cur_w[i]),
                .neq       (neq[i])
            );
        end
    endgenerate

    assign bus.pwm        = pwm_w;
    assign bus.cur_pos    = cur_w;
    assign bus.frame_tick = frame_tick_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_servo_pwm_multi.sv
// Frame-level checks of servo_pwm_multi against a per-frame arithmetic model.
module tb_servo_pwm_multi;
    localparam int CH = 2, PW = 8, FRAME = 300, MINU = 50, MAXU = 250, SLEW = 4;
    localparam int CENTRE = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    servo_pwm_multi_if #(.CHANNELS(CH), .POS_W(PW)) bus ();

    servo_pwm_multi #(
        .CLK_HZ(1_000_000), .CHANNELS(CH), .POS_W(PW), .FRAME_US(FRAME),
        .MIN_US(MINU), .MAX_US(MAXU), .SLEW_STEP(SLEW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks, errors;
    int m_cur[CH];
    int m_tgt[CH];
    bit m_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int step(input int cur, input int tgt);
        int d;
        d = tgt - cur;
        if (SLEW == 0 || (d <= SLEW && d >= -SLEW)) return tgt;
        return (d > 0) ? cur + SLEW : cur - SLEW;
    endfunction

    function automatic int wid(input int cur);
        return MINU + (cur * (MAXU - MINU)) / 256;
    endfunction

    function automatic int busy_model();
        for (int c = 0; c < CH; c++)
            if (m_cur[c] != m_tgt[c]) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_cur[c] = CENTRE;
            m_tgt[c] = CENTRE;
        end
    endtask

    // Wait for the first frame boundary after reset release; no pulse may appear before it.
    task automatic sync_first();
        int n, hi;
        n = 0;
        hi = 0;
        do begin
            @(negedge clk);
            n++;
            if (!bus.frame_tick) hi += int'(bus.pwm[0]) + int'(bus.pwm[1]);
        end while (!bus.frame_tick && n < 2*FRAME);
        chk("first_fb_delay", n, FRAME);
        chk("pre_fb_pwm", hi, 0);
    endtask

    // Entered at the negedge right after a frame boundary; returns at the next one.
    task automatic do_frame(input bit new_en, input bit do_load, input int load_off,
                            input int t0, input int t1, input int glitch);
        int hi[CH];
        int extra, w, exp_hi;
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("cur%0d", c), 32'(bus.cur_pos[c*PW +: PW]), 32'(m_cur[c]));
            hi[c] = 0;
        end
        chk("busy", 32'(bus.busy), 32'(busy_model()));
        extra = 0;
        for (int j = 0; j < FRAME; j++) begin
            for (int c = 0; c < CH; c++) hi[c] += int'(bus.pwm[c]);
            if (j > 0 && bus.frame_tick) extra++;
            if (glitch >= 0 && j == glitch + 1) chk("dis_edge", 32'(bus.pwm), 0);
            bus.load = do_load && (j == load_off);
            if (bus.load) begin
                bus.target_pos[0 +: PW]  = PW'(t0);
                bus.target_pos[PW +: PW] = PW'(t1);
            end
            if (j == glitch) bus.enable = 1'b0;
            if (glitch >= 0 && j == glitch + 1) bus.enable = m_en;
            if (j == FRAME - 1) bus.enable = new_en;
            @(negedge clk);
        end
        bus.load = 1'b0;
        chk("tick_period", 32'(bus.frame_tick), 1);
        chk("tick_width", extra, 0);
        for (int c = 0; c < CH; c++) begin
            w = wid(m_cur[c]);
            exp_hi = !m_en ? 0 : (glitch >= 0 && glitch + 1 < w) ? w - 1 : w;
            chk($sformatf("high%0d", c), hi[c], exp_hi);
        end
        if (do_load && load_off < FRAME - 1) begin
            m_tgt[0] = t0;
            m_tgt[1] = t1;
        end
        if (new_en)
            for (int c = 0; c < CH; c++) m_cur[c] = step(m_cur[c], m_tgt[c]);
        if (do_load && load_off == FRAME - 1) begin
            m_tgt[0] = t0;
            m_tgt[1] = t1;
        end
        m_en = new_en;
    endtask

    initial begin
        int r_off, r_t0, r_t1, r_g;
        bit r_en, r_ld;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.enable = 1'b1;
        bus.load = 1'b0;
        bus.target_pos = '0;
        m_en = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_pwm", 32'(bus.pwm), 0);
        chk("rst_tick", 32'(bus.frame_tick), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_cur", 32'(bus.cur_pos), 32'({8'd128, 8'd128}));
        rst = 1'b0;
        sync_first();
        do_frame(1, 0, 0, 0, 0, -1);
        do_frame(1, 0, 0, 0, 0, -1);

        // ch0 to full scale, ch1 held at centre
        do_frame(1, 1, 10, 255, CENTRE, -1);
        repeat (33) do_frame(1, 0, 0, 0, 0, -1);
        chk("ch0_final", 32'(bus.cur_pos[7:0]), 255);
        chk("ch0_idle", 32'(bus.busy), 0);

        // ch1 to zero, must stop at 0 without wrapping
        do_frame(1, 1, 50, 255, 0, -1);
        repeat (33) do_frame(1, 0, 0, 0, 0, -1);
        chk("ch1_final", 32'(bus.cur_pos[15:8]), 0);

        // asynchronous reset in the middle of ch0's pulse
        repeat (70) @(negedge clk);
        chk("mid_pulse", 32'(bus.pwm[0]), 1);
        rst = 1'b1;
        #1;
        chk("async_pwm", 32'(bus.pwm), 0);
        chk("async_cur", 32'(bus.cur_pos), 32'({8'd128, 8'd128}));
        chk("async_busy", 32'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        sync_first();

        // load coincident with the frame boundary takes effect one frame later
        do_frame(1, 1, FRAME - 1, 130, CENTRE, -1);
        chk("ldfb_hold", 32'(bus.cur_pos[7:0]), 128);
        do_frame(1, 0, 0, 0, 0, -1);
        chk("ldfb_apply", 32'(bus.cur_pos[7:0]), 130);
        do_frame(1, 0, 0, 0, 0, -1);

        // slew interrupted by three disabled frames
        do_frame(1, 1, 5, 200, 60, 20);
        do_frame(1, 0, 0, 0, 0, -1);
        do_frame(0, 0, 0, 0, 0, -1);
        do_frame(0, 0, 0, 0, 0, -1);
        do_frame(0, 0, 0, 0, 0, -1);
        do_frame(1, 0, 0, 0, 0, -1);
        do_frame(1, 0, 0, 0, 0, -1);

        repeat (40) begin
            r_en  = ($urandom_range(0, 3) != 0);
            r_ld  = $urandom_range(0, 1) != 0;
            r_off = int'($urandom_range(0, FRAME - 1));
            r_t0  = int'($urandom_range(0, 255));
            r_t1  = int'($urandom_range(0, 255));
            r_g   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, FRAME - 3)) : -1;
            do_frame(r_en, r_ld, r_off, r_t0, r_t1, r_g);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
